// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 PCLK-domain capture: RGB444 byte pairs to 12-bit FIFO writes
// Skips start-up frames, then packs pixels and flags overflow and line/frame geometry errors.
module ov7670_capture #(
  parameter int SKIP_FRAMES = 2,
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full_fifo,
  output logic        wr_en,
  output logic [11:0] dout,
  output logic        frame_done,
  output logic        overflow,
  output logic        geom_err
);

  typedef enum logic [1:0] {ST_SKIP, ST_SYNC, ST_CAPTURE} state_t;

  localparam int SKIP_W    = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam int SKIP_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;
  localparam state_t RST_STATE = (SKIP_FRAMES == 0) ? ST_SYNC : ST_SKIP;
  localparam logic [10:0] X_EXP = 11'(H_PIXELS);
  localparam logic [9:0]  Y_EXP = 10'(V_LINES);

  logic              vsync_q, vsync_p_q, href_q, href_p_q;
  logic [7:0]        data_q;
  state_t            state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [10:0]       x_q, x_d, x_inc;
  logic [9:0]        y_q, y_d, y_inc, y_line;
  logic              phase_q, phase_d;
  logic [3:0]        r_q, r_d;
  logic [11:0]       dout_q, dout_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              geom_err_q, geom_err_d;
  logic              vs_rise, vs_fall, href_fall;

  assign vs_rise   = vsync_q & ~vsync_p_q;
  assign vs_fall   = ~vsync_q & vsync_p_q;
  assign href_fall = href_p_q & ~href_q;
  // Saturating counters: a runaway line or frame still mismatches instead of wrapping
  assign x_inc = (x_q == 11'h7FF) ? x_q : x_q + 11'd1;
  assign y_inc = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    y_line       = y_q;
    phase_d      = phase_q;
    r_d          = r_q;
    dout_d       = dout_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    geom_err_d   = geom_err_q;
    case (state_q)
      ST_SKIP: begin
        if (vs_rise) begin
          if (skip_cnt_q == SKIP_W'(SKIP_LAST)) begin
            state_d    = ST_SYNC;
            skip_cnt_d = '0;
          end else begin
            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          end
        end
      end
      ST_SYNC: begin
        if (vs_fall) begin
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (href_fall) begin
          if (x_q != X_EXP || phase_q) geom_err_d = 1'b1;
          y_line  = y_inc;
          y_d     = y_inc;
          x_d     = '0;
          phase_d = 1'b0;
        end else if (href_q && !vs_rise) begin
          if (!phase_q) begin
            r_d     = data_q[3:0];
            phase_d = 1'b1;
          end else begin
            if (!full_fifo) begin
              dout_d  = {r_q, data_q};
              wr_en_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            x_d     = x_inc;
            phase_d = 1'b0;
          end
        end
        // Frame end sees the y already bumped by a coincident line end
        if (vs_rise) begin
          frame_done_d = 1'b1;
          if (y_line != Y_EXP) geom_err_d = 1'b1;
          state_d = ST_SYNC;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      vsync_p_q    <= 1'b0;
      href_q       <= 1'b0;
      href_p_q     <= 1'b0;
      data_q       <= '0;
      state_q      <= RST_STATE;
      skip_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      r_q          <= '0;
      dout_q       <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      geom_err_q   <= 1'b0;
    end else begin
      vsync_q      <= cam_vsync;
      vsync_p_q    <= vsync_q;
      href_q       <= cam_href;
      href_p_q     <= href_q;
      data_q       <= cam_data;
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      r_q          <= r_d;
      dout_q       <= dout_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      geom_err_q   <= geom_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign geom_err   = geom_err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - randomized frame-level bench for ov7670_capture
// Reference model tracks captured frames, expected pixels and sticky flags per frame.
module tb_ov7670_capture;

  localparam int SKIP = 2;
  localparam int H    = 24;
  localparam int V    = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        full_fifo = 1'b0;
  logic        wr_en;
  logic [11:0] dout;
  logic        frame_done;
  logic        overflow;
  logic        geom_err;

  ov7670_capture #(.SKIP_FRAMES(SKIP), .H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .full_fifo(full_fifo), .wr_en(wr_en), .dout(dout),
    .frame_done(frame_done), .overflow(overflow), .geom_err(geom_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];
  int          wr_cyc[$];
  int          cyc = 0;
  int          fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back(dout);
      wr_cyc.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
  end

  int   rises = 0;
  int   lines = 0;
  int   e_fd = 0;
  int   b1cyc = 0;
  bit   mcap = 1'b0;
  bit   e_ovf = 1'b0;
  bit   e_geom = 1'b0;
  logic pend_full = 1'b0;

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d, input logic fl);
    @(negedge clk);
    full_fifo = pend_full;
    pend_full = fl;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_dout", dout, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_geom", geom_err, 0);
    mcap = 1'b0; rises = 0; lines = 0; e_ovf = 1'b0; e_geom = 1'b0; e_fd = 0; fd_cnt = 0;
    exp_q.delete(); got_q.delete(); wr_cyc.delete();
    pend_full = 1'b0;
    full_fifo = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_line(input int npix, input bit extra, input int mode,
                           input int full_lo, input int full_hi, input int rst_at);
    logic [7:0] b0, b1;
    logic fl;
    if (mcap) begin
      lines++;
      if (npix != H || extra) e_geom = 1'b1;
    end
    for (int p = 0; p < npix; p++) begin
      b0 = (mode == 1) ? 8'h0A : 8'($urandom);
      b1 = (mode == 1) ? 8'hBC : 8'($urandom);
      if (mode == 2 && p == 0) begin b0 = 8'h01; b1 = 8'h23; end
      if (mode == 2 && p == 1) begin b0 = 8'h04; b1 = 8'h56; end
      fl = (p >= full_lo && p <= full_hi);
      tick(1'b0, 1'b1, b0, 1'b0);
      tick(1'b0, 1'b1, b1, fl);
      if (mode == 2 && p == 0) b1cyc = cyc;
      if (mcap) begin
        if (fl) e_ovf = 1'b1;
        else exp_q.push_back({b0[3:0], b1});
      end
      if (p == rst_at) begin
        #2;
        do_reset();
      end
    end
    if (extra) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input int nlines, input int mode, input int short_line,
                            input bit ovf, input int rst_line);
    int mism;
    int n;
    lines = 0;
    got_q.delete(); exp_q.delete(); wr_cyc.delete();
    repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int l = 0; l < nlines; l++)
      send_line((l == short_line) ? H - 1 : H, l == short_line,
                (mode == 2 && l != 0) ? 0 : mode,
                (ovf && l == 0) ? 10 : -1, (ovf && l == 0) ? 19 : -1,
                (l == rst_line) ? 5 : -1);
    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0);
    if (mcap) begin
      e_fd++;
      if (lines != V) e_geom = 1'b1;
    end
    rises++;
    if (rises >= SKIP) mcap = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
    mism = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check("n_writes", got_q.size(), exp_q.size());
    check("pix_mismatches", mism, 0);
    check("frame_done_cnt", fd_cnt, e_fd);
    check("overflow", overflow, e_ovf);
    check("geom_err", geom_err, e_geom);
  endtask

  initial begin
    #2;
    do_reset();
    send_frame(V, 0, -1, 1'b0, -1);
    send_frame(V, 0, -1, 1'b0, -1);
    check("skip_no_writes", got_q.size(), 0);
    send_frame(V, 1, -1, 1'b0, -1);
    check("const_frame_writes", got_q.size(), H * V);
    send_frame(V, 2, -1, 1'b0, -1);
    check("ord_two_writes", (wr_cyc.size() >= 2) ? 1 : 0, 1);
    if (wr_cyc.size() >= 2 && got_q.size() >= 2) begin
      check("ord_latency", wr_cyc[0] - b1cyc, 2);
      check("ord_gap", wr_cyc[1] - wr_cyc[0], 2);
      check("ord_pix0", got_q[0], 12'h123);
      check("ord_pix1", got_q[1], 12'h456);
    end
    send_frame(V, 0, -1, 1'b1, -1);
    check("ovf_frame_writes", got_q.size(), H * V - 10);
    send_frame(V, 0, -1, 1'b0, -1);
    send_frame(V, 0, 2, 1'b0, -1);
    check("short_line_writes", got_q.size(), H * V - 1);
    send_frame(V, 0, -1, 1'b0, 2);
    send_frame(V, 0, -1, 1'b0, -1);
    check("post_reset_no_writes", got_q.size(), 0);
    send_frame(V - 1, 0, -1, 1'b0, -1);
    send_frame(V, 0, -1, 1'b0, -1);
    check("recover_writes", got_q.size(), H * V);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
